// File: rtl/score_display_ctl.sv
// Scores enemy kills (rising edges weighted by enemy type), drains the points
// one per cycle into a saturating 4-digit BCD score, and scans it onto a 7-seg display.
module score_display_ctl #(
  parameter int N_ENEMY  = 10,
  parameter int TYPE_W   = 3,
  parameter int SCAN_DIV = 100000,
  parameter int BLANK_LZ = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [N_ENEMY-1:0]        eli_enemy,
  input  logic [N_ENEMY*TYPE_W-1:0] enemy_type,
  output logic [15:0]               score_bcd,
  output logic                      score_busy,
  output logic [3:0]                bit_dsp,
  output logic [7:0]                BCD_dsp
);

  localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  // Registered state
  logic [N_ENEMY-1:0] r_eli_prev;
  logic [7:0]         r_pending;
  logic [15:0]        r_score_bcd;
  logic               r_score_busy;
  logic [CNT_W-1:0]   r_scan_cnt;
  logic [1:0]         r_digit_idx;
  logic [3:0]         r_bit_dsp;
  logic [7:0]         r_seg;

  // Combinational signals
  logic [N_ENEMY-1:0] w_kill;
  logic [7:0]         w_add;
  logic               w_drain;
  logic [8:0]         w_pend_sum;
  logic [7:0]         w_pend_next;
  logic [15:0]        w_score_inc;
  logic [3:0]         w_digit;
  logic               w_blank;
  logic [7:0]         w_glyph;

  // Active-low {a,b,c,d,e,f,g,dp}; dp is always off.
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'b0000_0011;
      4'd1:    s = 8'b1001_1111;
      4'd2:    s = 8'b0010_0101;
      4'd3:    s = 8'b0000_1101;
      4'd4:    s = 8'b1001_1001;
      4'd5:    s = 8'b0100_1001;
      4'd6:    s = 8'b0100_0001;
      4'd7:    s = 8'b0001_1111;
      4'd8:    s = 8'b0000_0001;
      4'd9:    s = 8'b0000_1001;
      default: s = 8'b1111_1111;
    endcase
    return s;
  endfunction

  // BCD +1 with ripple carry between digits; 9999 holds.
  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (v[d*4 +: 4] == 4'd9) begin
            r[d*4 +: 4] = 4'd0;
          end else begin
            r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign w_kill = eli_enemy & ~r_eli_prev;

  always_comb begin
    w_add = 8'd0;
    for (int i = 0; i < N_ENEMY; i++) begin
      if (w_kill[i]) begin
        w_add = w_add + 8'(enemy_type[i*TYPE_W +: TYPE_W]) + 8'd1;
      end
    end
  end

  // pending + add fits in 9 bits; drain never underflows because it needs pending != 0.
  assign w_drain     = (r_pending != 8'd0);
  assign w_pend_sum  = {1'b0, r_pending} + {1'b0, w_add} - {8'd0, w_drain};
  assign w_pend_next = w_pend_sum[8] ? 8'hFF : w_pend_sum[7:0];
  assign w_score_inc = bcd_inc_sat(r_score_bcd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_eli_prev   <= '0;
      r_pending    <= 8'd0;
      r_score_bcd  <= 16'h0000;
      r_score_busy <= 1'b0;
    end else begin
      r_eli_prev <= eli_enemy;
      if (clr) begin
        r_pending    <= 8'd0;
        r_score_bcd  <= 16'h0000;
        r_score_busy <= 1'b0;
      end else begin
        r_pending    <= w_pend_next;
        r_score_busy <= (w_pend_next != 8'd0);
        if (w_drain) begin
          r_score_bcd <= w_score_inc;
        end
      end
    end
  end

  // A digit is blanked when it and every digit above it are zero.
  always_comb begin
    w_digit = r_score_bcd[3:0];
    w_blank = 1'b0;
    case (r_digit_idx)
      2'd0: begin
        w_digit = r_score_bcd[3:0];
        w_blank = 1'b0;
      end
      2'd1: begin
        w_digit = r_score_bcd[7:4];
        w_blank = (r_score_bcd[15:4] == 12'h000);
      end
      2'd2: begin
        w_digit = r_score_bcd[11:8];
        w_blank = (r_score_bcd[15:8] == 8'h00);
      end
      default: begin
        w_digit = r_score_bcd[15:12];
        w_blank = (r_score_bcd[15:12] == 4'h0);
      end
    endcase
    w_glyph = ((BLANK_LZ != 0) && w_blank) ? 8'hFF : seg_of(w_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= 2'd0;
      r_bit_dsp   <= 4'b1110;
      r_seg       <= 8'b0000_0011;
    end else begin
      if (r_scan_cnt == CNT_LAST) begin
        r_scan_cnt  <= '0;
        r_digit_idx <= r_digit_idx + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      r_bit_dsp <= ~(4'b0001 << r_digit_idx);
      r_seg     <= w_glyph;
    end
  end

  assign score_bcd  = r_score_bcd;
  assign score_busy = r_score_busy;
  assign bit_dsp    = r_bit_dsp;
  assign BCD_dsp    = r_seg;

endmodule

// File: tb/tb_score_display_ctl.sv
// Bench for score_display_ctl: integer-level score model checked every cycle,
// directed scenarios with literal expectations, then randomized kills/clears/resets.
module tb_score_display_ctl;

  localparam int N  = 10;
  localparam int TW = 3;
  localparam int SD = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [N-1:0]    eli   = '0;
  logic [N*TW-1:0] etype = '0;

  logic [15:0] score_bcd;
  logic        score_busy;
  logic [3:0]  bit_dsp;
  logic [7:0]  BCD_dsp;

  always #5 clk = ~clk;

  score_display_ctl #(
    .N_ENEMY (N),
    .TYPE_W  (TW),
    .SCAN_DIV(SD),
    .BLANK_LZ(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .eli_enemy (eli),
    .enemy_type(etype),
    .score_bcd (score_bcd),
    .score_busy(score_busy),
    .bit_dsp   (bit_dsp),
    .BCD_dsp   (BCD_dsp)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: plain integers for score and pending points
  logic [7:0] glyph_tab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
  int p10 [4] = '{1, 10, 100, 1000};

  bit         m_valid = 1'b0;
  int         m_score, m_pend, m_n;
  logic [N-1:0] m_prev;
  logic [3:0] m_bit;
  logic [7:0] m_seg;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) begin
    int idx, add;
    if (rst) begin
      m_valid = 1'b1;
      m_score = 0;
      m_pend  = 0;
      m_n     = 0;
      m_prev  = '0;
      m_bit   = 4'b1110;
      m_seg   = 8'h03;
    end else if (m_valid) begin
      // the display shows the digit selected before this edge, from the score before this edge
      idx   = (m_n / SD) % 4;
      m_bit = ~(4'b0001 << idx);
      if (idx > 0 && m_score < p10[idx]) m_seg = 8'hFF;
      else m_seg = glyph_tab[(m_score / p10[idx]) % 10];
      m_n++;
      add = 0;
      for (int i = 0; i < N; i++)
        if (eli[i] && !m_prev[i]) add += int'(etype[i*TW +: TW]) + 1;
      if (clr) begin
        m_pend  = 0;
        m_score = 0;
      end else begin
        if (m_pend > 0) begin
          if (m_score < 9999) m_score++;
          m_pend--;
        end
        m_pend = m_pend + add;
        if (m_pend > 255) m_pend = 255;
      end
      m_prev = eli;
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (m_valid) begin
      chk("score_bcd", score_bcd, to_bcd(m_score));
      chk("score_busy", score_busy, (m_pend != 0));
      chk("bit_dsp", bit_dsp, m_bit);
      chk("BCD_dsp", BCD_dsp, m_seg);
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  task automatic load_points(input int pts, output logic [N-1:0] mask);
    int rem;
    rem   = pts;
    mask  = '0;
    etype = '0;
    for (int i = 0; i < N; i++) begin
      if (rem >= 8) begin
        etype[i*TW +: TW] = 3'd7;
        mask[i] = 1'b1;
        rem -= 8;
      end else if (rem > 0) begin
        etype[i*TW +: TW] = TW'(rem - 1);
        mask[i] = 1'b1;
        rem = 0;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (score_busy !== 1'b0 && k < 400) begin
      step(1);
      k++;
    end
    chk(name, score_busy, 1'b0);
  endtask

  task automatic add_points(input int pts);
    logic [N-1:0] mask;
    int chunk;
    while (pts > 0) begin
      chunk = (pts > 80) ? 80 : pts;
      load_points(chunk, mask);
      eli = mask;
      step(1);
      eli = '0;
      step(1);
      wait_idle("drain_idle");
      pts -= chunk;
    end
  endtask

  initial begin
    logic [N-1:0] mask;

    // 1. reset and scan
    rst = 1'b1;
    step(2);
    chk("rst_score", score_bcd, 16'h0000);
    chk("rst_busy", score_busy, 1'b0);
    chk("rst_bit", bit_dsp, 4'b1110);
    chk("rst_seg", BCD_dsp, 8'h03);
    rst = 1'b0;
    step(1);
    chk("scan0_bit", bit_dsp, 4'b1110);
    chk("scan0_seg", BCD_dsp, 8'h03);
    step(4);
    chk("scan1_bit", bit_dsp, 4'b1101);
    chk("scan1_seg", BCD_dsp, 8'hFF);
    step(4);
    chk("scan2_bit", bit_dsp, 4'b1011);
    chk("scan2_seg", BCD_dsp, 8'hFF);
    step(4);
    chk("scan3_bit", bit_dsp, 4'b0111);
    chk("scan3_seg", BCD_dsp, 8'hFF);
    step(4);
    chk("scan_wrap_bit", bit_dsp, 4'b1110);

    // 2. single kill, slot 3 type 2, held high
    etype = '0;
    etype[3*TW +: TW] = 3'd2;
    eli = 10'b00_0000_1000;
    step(1);
    chk("k_busy", score_busy, 1'b1);
    chk("k_score", score_bcd, 16'h0000);
    step(1);
    chk("k1_score", score_bcd, 16'h0001);
    step(1);
    chk("k2_score", score_bcd, 16'h0002);
    step(1);
    chk("k3_score", score_bcd, 16'h0003);
    chk("k3_busy", score_busy, 1'b0);
    step(2);
    chk("held_score", score_bcd, 16'h0003);
    eli = '0;
    step(1);

    // 3. simultaneous kills, then a kill during drain
    do_clr();
    etype = '0;
    etype[5*TW +: TW] = 3'd7;
    etype[9*TW +: TW] = 3'd4;
    eli = 10'b10_0010_0001;
    step(1);
    eli = '0;
    step(14);
    chk("multi_score", score_bcd, 16'h0014);
    chk("multi_busy", score_busy, 1'b0);
    do_clr();
    eli = 10'b10_0010_0001;
    step(1);
    eli = '0;
    step(3);
    chk("mid_score", score_bcd, 16'h0003);
    etype[1*TW +: TW] = 3'd1;
    eli = 10'b00_0000_0010;
    step(1);
    eli = '0;
    chk("mid2_score", score_bcd, 16'h0004);
    chk("mid2_busy", score_busy, 1'b1);
    wait_idle("second_idle");
    chk("second_score", score_bcd, 16'h0016);

    // 4. BCD carry and saturation
    do_clr();
    add_points(999);
    chk("pre_999", score_bcd, 16'h0999);
    add_points(1);
    chk("carry_1000", score_bcd, 16'h1000);
    add_points(8995);
    chk("pre_9995", score_bcd, 16'h9995);
    load_points(8, mask);
    eli = mask;
    step(1);
    eli = '0;
    chk("sat_busy0", score_busy, 1'b1);
    step(7);
    chk("sat_score7", score_bcd, 16'h9999);
    chk("sat_busy7", score_busy, 1'b1);
    step(1);
    chk("sat_score8", score_bcd, 16'h9999);
    chk("sat_busy8", score_busy, 1'b0);

    // 5. pending saturation
    do_clr();
    etype = '1;
    for (int r = 0; r < 4; r++) begin
      eli = '1;
      step(1);
      eli = '0;
      step(1);
    end
    chk("fill_score", score_bcd, 16'h0007);
    wait_idle("fill_idle");
    chk("fill_final", score_bcd, 16'h0261);

    // 6. clr during drain with a coincident kill
    do_clr();
    load_points(20, mask);
    eli = mask;
    step(1);
    eli = '0;
    step(5);
    chk("clr_pre", score_bcd, 16'h0005);
    clr = 1'b1;
    eli = 10'b00_0000_1000;
    step(1);
    clr = 1'b0;
    chk("clr_score", score_bcd, 16'h0000);
    chk("clr_busy", score_busy, 1'b0);
    step(3);
    chk("clr_held_score", score_bcd, 16'h0000);
    chk("clr_held_busy", score_busy, 1'b0);
    eli = '0;
    step(1);
    eli = 10'b00_0000_1000;
    step(1);
    chk("rearm_busy", score_busy, 1'b1);
    step(1);
    chk("rearm_score", score_bcd, 16'h0001);
    eli = '0;

    // reset mid-drain
    etype = '1;
    eli = '1;
    step(1);
    eli = '0;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rstmid_score", score_bcd, 16'h0000);
    chk("rstmid_busy", score_busy, 1'b0);
    chk("rstmid_bit", bit_dsp, 4'b1110);

    // randomized kills, types, clears and resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) eli[i] = ~eli[i];
      if ($urandom_range(0, 7) == 0) etype = (N*TW)'($urandom);
      clr = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step(1);
    end
    rst = 1'b0;
    clr = 1'b0;
    eli = '0;
    wait_idle("rand_idle");
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
